mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, memory address width.
REQ-002 SHALL have parameter DATA_W, default 32, memory data width.
REQ-003 SHALL have parameter STARVE_MAX, default 4, maximum consecutive data grants while fetch is waiting.
REQ-004 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have ports if_req in 1 (fetch request), if_addr in ADDR_W, if_rdata out DATA_W, if_ack out 1.
REQ-007 SHALL have ports dm_req in 1, dm_we in 1, dm_addr in ADDR_W, dm_wdata in DATA_W (data-stage access), dm_rdata out DATA_W, dm_ack out 1.
REQ-008 SHALL have ports mem_en out 1, mem_we out 1, mem_addr out ADDR_W, mem_wdata out DATA_W, mem_rdata in DATA_W, mem_rdy in 1 (shared single-port memory).
REQ-009 SHALL have ports stall_if out 1 and stall_mem out 1 (pipeline freeze requests).

Function
REQ-010 SHALL implement FSM states IDLE, GNT_I, GNT_D.
REQ-011 IDLE: dm_req=1 -> GNT_D, else if_req=1 -> GNT_I, else stay; exception under REQ-012.
REQ-012 Starvation guard: counter increments on each GNT_D entry while if_req=1, clears on GNT_I entry; when counter == STARVE_MAX and both requests are high, grant I.
REQ-013 On a grant, SHALL register the winner's addr, we (fetch: 0), and wdata into mem_addr, mem_we, and mem_wdata; mem_en=1 throughout GNT_I/GNT_D; all mem_* outputs held stable until mem_rdy.
REQ-014 In GNT_x with mem_rdy=1: SHALL capture mem_rdata into x_rdata (reads only), pulse x_ack=1 for exactly the next cycle, and return to IDLE.
REQ-015 Writes: dm_ack pulses as for reads; dm_rdata SHALL keep its previous value.
REQ-016 In the cycle x_ack=1, requester x's req SHALL be ignored by arbitration, so no re-grant occurs on a stale request.
REQ-017 Latency: with req in IDLE at cycle 0 and mem_rdy at cycle k>=1, ack SHALL occur at cycle k+1.
REQ-018 mem_rdy outside GNT_I/GNT_D SHALL be ignored.
REQ-019 stall_if = if_req & ~if_ack; stall_mem = dm_req & ~dm_ack; both combinational.
REQ-020 if_rdata/dm_rdata SHALL hold their last captured values until the next read completion for that port.
REQ-021 Request drop while granted: the access still completes; the ack still pulses.

Reset
REQ-022 rst=0 SHALL immediately force IDLE, mem_en=0, mem_we=0, if_ack=0, dm_ack=0, and starvation counter=0.
REQ-023 Reset SHALL clear mem_addr, mem_wdata, if_rdata, and dm_rdata to 0.
REQ-024 Reset mid-transaction SHALL abandon the access with no ack; a mem_rdy arriving after reset release while in IDLE SHALL be ignored.

Structure
REQ-025 Package mem_arb_pkg SHALL hold the state encoding (IDLE=2'd0, GNT_I=2'd1, GNT_D=2'd2) and the STARVE_MAX default.
REQ-026 No sub-module; single flat module with FSM, starvation counter, and output registers.

Verification
REQ-027 Lone fetch: if_req=1, if_addr=0x00000040, memory returns 0x8C010004 with mem_rdy at cycle 2 -> if_ack at cycle 3, if_rdata=0x8C010004, stall_if=1 for cycles 0-2.
REQ-028 Simultaneous requests: if_req=dm_req=1 at cycle 0, dm_addr=0x100 load -> data granted first, fetch granted next, mem_addr sequence 0x100 then if_addr.
REQ-029 Starvation: if_req held high, dm_req re-asserted every IDLE -> after 4 GNT_D, a GNT_I occurs; the counter then clears.
REQ-030 Write: dm_we=1, dm_addr=0x200, dm_wdata=0xDEADBEEF -> mem_we=1 and mem_wdata=0xDEADBEEF stable until mem_rdy; dm_ack pulses once; dm_rdata unchanged.
REQ-031 Reset mid-GNT_D: rst=0 one cycle after grant -> mem_en=0 at once, no dm_ack; late mem_rdy ignored.
REQ-032 Wait states: mem_rdy delayed 5 cycles -> mem_* outputs stable throughout; exactly one ack.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared definitions for the instruction/data memory arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_I = 2'd1,
    GNT_D = 2'd2
  } arb_state_e;

  localparam int unsigned STARVE_MAX_DEFAULT = 4;

endpackage

// File: rtl/mem_arbiter.sv
// Arbitrates a single-port memory between instruction fetch and the data stage.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned STARVE_MAX = STARVE_MAX_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ack,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_ack,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_rdy,
  output logic              stall_if,
  output logic              stall_mem
);

  localparam int unsigned CNT_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);

  arb_state_e        state_q, state_d;
  logic [CNT_W-1:0]  starve_q, starve_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              we_q, we_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;
  logic              if_ack_q, if_ack_d;
  logic              dm_ack_q, dm_ack_d;
  logic              if_eff, dm_eff;

  // State and output registers; reset abandons any access in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      starve_q   <= '0;
      addr_q     <= '0;
      we_q       <= 1'b0;
      wdata_q    <= '0;
      if_rdata_q <= '0;
      dm_rdata_q <= '0;
      if_ack_q   <= 1'b0;
      dm_ack_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      starve_q   <= starve_d;
      addr_q     <= addr_d;
      we_q       <= we_d;
      wdata_q    <= wdata_d;
      if_rdata_q <= if_rdata_d;
      dm_rdata_q <= dm_rdata_d;
      if_ack_q   <= if_ack_d;
      dm_ack_q   <= dm_ack_d;
    end
  end

  // Arbitration, starvation guard and transfer completion.
  always_comb begin
    state_d    = state_q;
    starve_d   = starve_q;
    addr_d     = addr_q;
    we_d       = we_q;
    wdata_d    = wdata_q;
    if_rdata_d = if_rdata_q;
    dm_rdata_d = dm_rdata_q;
    if_ack_d   = 1'b0;
    dm_ack_d   = 1'b0;
    // A requester being acked this cycle still shows its old request; mask it.
    if_eff     = if_req & ~if_ack_q;
    dm_eff     = dm_req & ~dm_ack_q;
    case (state_q)
      IDLE: begin
        if (if_eff && (!dm_eff || starve_q == CNT_W'(STARVE_MAX))) begin
          state_d  = GNT_I;
          addr_d   = if_addr;
          we_d     = 1'b0;
          wdata_d  = '0;
          starve_d = '0;
        end else if (dm_eff) begin
          state_d = GNT_D;
          addr_d  = dm_addr;
          we_d    = dm_we;
          wdata_d = dm_wdata;
          if (if_eff) begin
            starve_d = starve_q + CNT_W'(1);
          end
        end
      end
      GNT_I: begin
        if (mem_rdy) begin
          if_rdata_d = mem_rdata;
          if_ack_d   = 1'b1;
          state_d    = IDLE;
        end
      end
      GNT_D: begin
        if (mem_rdy) begin
          if (!we_q) begin
            dm_rdata_d = mem_rdata;
          end
          dm_ack_d = 1'b1;
          we_d     = 1'b0;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign mem_en    = (state_q != IDLE);
  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign if_rdata  = if_rdata_q;
  assign dm_rdata  = dm_rdata_q;
  assign if_ack    = if_ack_q;
  assign dm_ack    = dm_ack_q;
  assign stall_if  = if_req & ~if_ack_q;
  assign stall_mem = dm_req & ~dm_ack_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: per-cycle vector table plus multi-cycle sequences.
module tb_mem_arbiter;

  typedef struct packed {
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic        dm_req;
    logic        dm_we;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic [31:0] mem_rdata;
    logic        mem_rdy;
  } vin_t;

  typedef struct packed {
    logic        mem_en;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        if_ack;
    logic        dm_ack;
    logic [31:0] if_rdata;
    logic [31:0] dm_rdata;
    logic        stall_if;
    logic        stall_mem;
  } vout_t;

  typedef struct {
    string name;
    vin_t  i;
    vout_t o;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_ack;
  logic        dm_req;
  logic        dm_we;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic [31:0] dm_rdata;
  logic        dm_ack;
  logic        mem_en;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_rdy;
  logic        stall_if;
  logic        stall_mem;

  int unsigned n_pass  = 0;
  int unsigned n_total = 0;
  vec_t        tbl[$];

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_MAX(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_rdata  (if_rdata),
    .if_ack    (if_ack),
    .dm_req    (dm_req),
    .dm_we     (dm_we),
    .dm_addr   (dm_addr),
    .dm_wdata  (dm_wdata),
    .dm_rdata  (dm_rdata),
    .dm_ack    (dm_ack),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_rdy   (mem_rdy),
    .stall_if  (stall_if),
    .stall_mem (stall_mem)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach the end of the test");
    $fatal(1);
  end

  function automatic vin_t vi(input logic r, input logic ir, input logic [31:0] ia,
                              input logic dr, input logic dw, input logic [31:0] da,
                              input logic [31:0] dwd, input logic [31:0] rd, input logic rdy);
    vin_t v;
    v = '{rst: r, if_req: ir, if_addr: ia, dm_req: dr, dm_we: dw, dm_addr: da,
          dm_wdata: dwd, mem_rdata: rd, mem_rdy: rdy};
    return v;
  endfunction

  function automatic vout_t vo(input logic en, input logic we, input logic [31:0] a,
                               input logic [31:0] wd, input logic ia, input logic da,
                               input logic [31:0] ird, input logic [31:0] drd,
                               input logic si, input logic sm);
    vout_t v;
    v = '{mem_en: en, mem_we: we, mem_addr: a, mem_wdata: wd, if_ack: ia, dm_ack: da,
          if_rdata: ird, dm_rdata: drd, stall_if: si, stall_mem: sm};
    return v;
  endfunction

  function automatic vout_t sample();
    vout_t v;
    v = '{mem_en: mem_en, mem_we: mem_we, mem_addr: mem_addr, mem_wdata: mem_wdata,
          if_ack: if_ack, dm_ack: dm_ack, if_rdata: if_rdata, dm_rdata: dm_rdata,
          stall_if: stall_if, stall_mem: stall_mem};
    return v;
  endfunction

  task automatic add(input string n, input vin_t i, input vout_t o);
    vec_t v;
    v.name = n;
    v.i    = i;
    v.o    = o;
    tbl.push_back(v);
  endtask

  task automatic drive(input vin_t v);
    rst       = v.rst;
    if_req    = v.if_req;
    if_addr   = v.if_addr;
    dm_req    = v.dm_req;
    dm_we     = v.dm_we;
    dm_addr   = v.dm_addr;
    dm_wdata  = v.dm_wdata;
    mem_rdata = v.mem_rdata;
    mem_rdy   = v.mem_rdy;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, got, exp);
  endtask

  task automatic chk1(input string name, input logic got, input logic exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b", name, got, exp);
  endtask

  task automatic chk_vec(input string name, input vout_t got, input vout_t exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got en=%b we=%b addr=%h wd=%h iack=%b dack=%b ird=%h drd=%h sif=%b smem=%b expected en=%b we=%b addr=%h wd=%h iack=%b dack=%b ird=%h drd=%h sif=%b smem=%b",
                  name, got.mem_en, got.mem_we, got.mem_addr, got.mem_wdata, got.if_ack,
                  got.dm_ack, got.if_rdata, got.dm_rdata, got.stall_if, got.stall_mem,
                  exp.mem_en, exp.mem_we, exp.mem_addr, exp.mem_wdata, exp.if_ack,
                  exp.dm_ack, exp.if_rdata, exp.dm_rdata, exp.stall_if, exp.stall_mem);
  endtask

  // One data-vs-fetch contest; fetch request is dropped in the ack cycle so the
  // next round starts from a fresh simultaneous request.
  task automatic starve_round(input string tag, input logic [31:0] dm_a, input logic exp_i);
    if_req  = 1'b1;
    if_addr = 32'h0000_00A0;
    dm_req  = 1'b1;
    dm_we   = 1'b0;
    dm_addr = dm_a;
    mem_rdy = 1'b0;
    tick();
    #4;
    chk1({tag, "_en"}, mem_en, 1'b1);
    chk({tag, "_addr"}, mem_addr, exp_i ? 32'h0000_00A0 : dm_a);
    mem_rdy   = 1'b1;
    mem_rdata = 32'h6000_0000 | dm_a;
    tick();
    mem_rdy = 1'b0;
    if_req  = 1'b0;
    dm_req  = 1'b0;
    #4;
    chk1({tag, "_ack"}, exp_i ? if_ack : dm_ack, 1'b1);
    tick();
  endtask

  initial begin
    int acks;

    // name, vi(rst,if_req,if_addr,dm_req,dm_we,dm_addr,dm_wdata,mem_rdata,mem_rdy)
    //       vo(en,we,addr,wdata,if_ack,dm_ack,if_rdata,dm_rdata,stall_if,stall_mem)
    add("rst_hold",   vi(0,0,0,0,0,0,0,0,0), vo(0,0,0,0,0,0,0,0,0,0));
    add("idle",       vi(1,0,0,0,0,0,0,0,0), vo(0,0,0,0,0,0,0,0,0,0));
    add("fetch_c0",   vi(1,1,32'h40,0,0,0,0,0,0), vo(0,0,0,0,0,0,0,0,1,0));
    add("fetch_c1",   vi(1,1,32'h40,0,0,0,0,0,0), vo(1,0,32'h40,0,0,0,0,0,1,0));
    add("fetch_c2",   vi(1,1,32'h40,0,0,0,0,32'h8C010004,1), vo(1,0,32'h40,0,0,0,0,0,1,0));
    add("fetch_ack",  vi(1,1,32'h40,0,0,0,0,0,0), vo(0,0,32'h40,0,1,0,32'h8C010004,0,0,0));
    add("fetch_nore", vi(1,0,0,0,0,0,0,0,0), vo(0,0,32'h40,0,0,0,32'h8C010004,0,0,0));
    add("sim_c0",     vi(1,1,32'h80,1,0,32'h100,0,0,0), vo(0,0,32'h40,0,0,0,32'h8C010004,0,1,1));
    add("sim_gnt_d",  vi(1,1,32'h80,1,0,32'h100,0,32'h11112222,1), vo(1,0,32'h100,0,0,0,32'h8C010004,0,1,1));
    add("sim_dack",   vi(1,1,32'h80,1,0,32'h100,0,0,0), vo(0,0,32'h100,0,0,1,32'h8C010004,32'h11112222,1,0));
    add("sim_gnt_i",  vi(1,1,32'h80,0,0,0,0,32'h33334444,1), vo(1,0,32'h80,0,0,0,32'h8C010004,32'h11112222,1,0));
    add("sim_iack",   vi(1,0,0,0,0,0,0,0,0), vo(0,0,32'h80,0,1,0,32'h33334444,32'h11112222,0,0));
    add("wr_c0",      vi(1,0,0,1,1,32'h200,32'hDEADBEEF,0,0), vo(0,0,32'h80,0,0,0,32'h33334444,32'h11112222,0,1));
    add("wr_g1",      vi(1,0,0,1,1,32'h200,32'hDEADBEEF,32'hBADBAD00,0), vo(1,1,32'h200,32'hDEADBEEF,0,0,32'h33334444,32'h11112222,0,1));
    add("wr_g2",      vi(1,0,0,1,1,32'h204,32'hCAFEF00D,32'hBADBAD00,0), vo(1,1,32'h200,32'hDEADBEEF,0,0,32'h33334444,32'h11112222,0,1));
    add("wr_rdy",     vi(1,0,0,1,1,32'h204,32'hCAFEF00D,32'hBADBAD00,1), vo(1,1,32'h200,32'hDEADBEEF,0,0,32'h33334444,32'h11112222,0,1));
    add("wr_ack",     vi(1,0,0,0,0,0,0,32'hBADBAD00,0), vo(0,0,32'h200,32'hDEADBEEF,0,1,32'h33334444,32'h11112222,0,0));
    add("rdy_idle",   vi(1,0,0,0,0,0,0,32'h77777777,1), vo(0,0,32'h200,32'hDEADBEEF,0,0,32'h33334444,32'h11112222,0,0));
    add("rdy_idle2",  vi(1,0,0,0,0,0,0,0,0), vo(0,0,32'h200,32'hDEADBEEF,0,0,32'h33334444,32'h11112222,0,0));
    add("rst_c0",     vi(1,0,0,1,0,32'h300,0,0,0), vo(0,0,32'h200,32'hDEADBEEF,0,0,32'h33334444,32'h11112222,0,1));
    add("rst_gnt",    vi(1,0,0,1,0,32'h300,0,0,0), vo(1,0,32'h300,0,0,0,32'h33334444,32'h11112222,0,1));
    add("rst_async",  vi(0,0,0,1,0,32'h300,0,0,0), vo(0,0,0,0,0,0,0,0,0,1));
    add("rst_lrdy1",  vi(1,0,0,0,0,0,0,32'h55555555,1), vo(0,0,0,0,0,0,0,0,0,0));
    add("rst_lrdy2",  vi(1,0,0,0,0,0,0,32'h55555555,1), vo(0,0,0,0,0,0,0,0,0,0));
    add("rst_quiet",  vi(1,0,0,0,0,0,0,0,0), vo(0,0,0,0,0,0,0,0,0,0));

    foreach (tbl[k]) begin
      drive(tbl[k].i);
      #4;
      chk_vec(tbl[k].name, sample(), tbl[k].o);
      tick();
    end

    // Fetch with five wait states while the requester's address wanders.
    if_req  = 1'b1;
    if_addr = 32'h0000_00C0;
    dm_req  = 1'b0;
    mem_rdy = 1'b0;
    tick();
    for (int i = 0; i < 5; i++) begin
      if_addr = 32'h0000_0F00 + 32'(i * 4);
      #4;
      chk1("ws_en", mem_en, 1'b1);
      chk1("ws_we", mem_we, 1'b0);
      chk("ws_addr", mem_addr, 32'h0000_00C0);
      chk("ws_wdata", mem_wdata, 32'h0);
      chk1("ws_noack", if_ack, 1'b0);
      tick();
    end
    mem_rdy   = 1'b1;
    mem_rdata = 32'h0BAD_F00D;
    #4;
    chk("ws_addr_rdy", mem_addr, 32'h0000_00C0);
    tick();
    mem_rdy = 1'b0;
    if_req  = 1'b0;
    acks    = 0;
    for (int i = 0; i < 4; i++) begin
      #4;
      if (i == 0) chk1("ws_ack_latency", if_ack, 1'b1);
      acks += int'(if_ack);
      tick();
    end
    chk("ws_ack_count", acks, 32'd1);
    chk("ws_rdata", if_rdata, 32'h0BAD_F00D);

    // Four data wins while fetch waits, then the guard grants fetch,
    // then the cleared counter lets data win again.
    starve_round("starve_d1", 32'h0000_1000, 1'b0);
    starve_round("starve_d2", 32'h0000_1004, 1'b0);
    starve_round("starve_d3", 32'h0000_1008, 1'b0);
    starve_round("starve_d4", 32'h0000_100C, 1'b0);
    starve_round("starve_i",  32'h0000_1010, 1'b1);
    starve_round("starve_clr", 32'h0000_1014, 1'b0);
    chk("starve_dm_rdata", dm_rdata, 32'h6000_1014);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
